// File: rtl/spi_dac_transmitter.sv
// rtl/spi_dac_transmitter.sv - paces the waveform generator and serializes each sample
// to a mode-0 SPI DAC as offset binary, MSB first, one frame per sample.
`timescale 1ns/1ps

module spi_dac_transmitter #(
    parameter int N_FRAC  = 7,
    parameter int CLK_DIV = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_FRAC:0]   data_i,
    input  logic              data_valid_strobe_i,
    output logic              next_data_strobe_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_n_o,
    output logic              unexpected_o
);

    localparam int W     = N_FRAC + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [W-1:0]     shift_q;
    logic             next_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             cs_n_q;
    logic             unexp_q;

    logic [W-1:0]     sample_d;
    logic             div_tc;

    // Two's complement to offset binary is just an inverted sign bit.
    assign sample_d = {~data_i[N_FRAC], data_i[N_FRAC-1:0]};
    assign div_tc   = (div_q == DIV_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            next_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            unexp_q   <= 1'b0;
        end else begin
            next_q <= 1'b0;
            if (data_valid_strobe_i && (state_q != S_WAIT)) begin
                unexp_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    next_q  <= 1'b1;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (data_valid_strobe_i) begin
                        // MSB goes straight to the pin; shift_q keeps the remaining bits.
                        mosi_q    <= sample_d[W-1];
                        shift_q   <= {sample_d[W-2:0], 1'b0};
                        cs_n_q    <= 1'b0;
                        sclk_q    <= 1'b0;
                        div_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (div_tc) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= {shift_q[W-2:0], 1'b0};
                            if (bit_cnt_q == BIT_LAST) begin
                                mosi_q  <= 1'b0;
                                cs_n_q  <= 1'b1;
                                state_q <= S_GAP;
                            end else begin
                                mosi_q <= shift_q[W-1];
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                S_GAP: begin
                    if (div_tc) begin
                        div_q   <= '0;
                        next_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign next_data_strobe_o = next_q;
    assign sclk_o             = sclk_q;
    assign mosi_o             = mosi_q;
    assign cs_n_o             = cs_n_q;
    assign unexpected_o       = unexp_q;

endmodule

// File: tb/tb_spi_dac_transmitter.sv
// tb/tb_spi_dac_transmitter.sv - scoreboard bench for spi_dac_transmitter (CLK_DIV 4 and 1).
`timescale 1ns/1ps

module tb_spi_dac_transmitter;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rst1_n;
    logic [1:0][7:0] data;
    logic [1:0]      valid;
    wire  [1:0]      req;
    wire  [1:0]      sclk;
    wire  [1:0]      mosi;
    wire  [1:0]      cs_n;
    wire  [1:0]      unexp;

    always #5 clk = ~clk;

    spi_dac_transmitter #(.N_FRAC(7), .CLK_DIV(4)) dut0 (
        .clk_i               (clk),
        .rst_i               (rst_n),
        .data_i              (data[0]),
        .data_valid_strobe_i (valid[0]),
        .next_data_strobe_o  (req[0]),
        .sclk_o              (sclk[0]),
        .mosi_o              (mosi[0]),
        .cs_n_o              (cs_n[0]),
        .unexpected_o        (unexp[0])
    );

    spi_dac_transmitter #(.N_FRAC(7), .CLK_DIV(1)) dut1 (
        .clk_i               (clk),
        .rst_i               (rst1_n),
        .data_i              (data[1]),
        .data_valid_strobe_i (valid[1]),
        .next_data_strobe_o  (req[1]),
        .sclk_o              (sclk[1]),
        .mosi_o              (mosi[1]),
        .cs_n_o              (cs_n[1]),
        .unexpected_o        (unexp[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int div_of(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] to_offset(input logic [7:0] s);
        int v;
        v = int'($signed(s)) + 128;
        return 8'(v);
    endfunction

    // Frame decoder: samples MOSI on each SCLK rising edge inside CS low.
    logic [1:0] p_sclk = '0, p_cs = '1, p_mosi = '0;
    logic [7:0] shreg [2];
    int         nbits [2];
    int         lowcnt [2];
    int         rise_cyc [2];
    bit         have_rise [2];
    int         viol [2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            shreg[g] = '0; nbits[g] = 0; lowcnt[g] = 0;
            rise_cyc[g] = 0; have_rise[g] = 0; viol[g] = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic       rv;
            logic [7:0] e;
            int         sz;
            rv = (g == 0) ? rst_n : rst1_n;
            if (!rv) begin
                nbits[g] = 0; lowcnt[g] = 0; have_rise[g] = 0; shreg[g] = '0;
            end else begin
                if (!cs_n[g]) lowcnt[g]++;
                if (!p_sclk[g] && sclk[g] && !cs_n[g]) begin
                    shreg[g] = {shreg[g][6:0], mosi[g]};
                    nbits[g]++;
                end
                if ((sclk[g] != p_sclk[g]) && cs_n[g] && p_cs[g]) viol[g]++;
                if ((mosi[g] != p_mosi[g]) && sclk[g]) viol[g]++;
                if (cs_n[g] && !p_cs[g]) begin
                    sz = (g == 0) ? q0.size() : q1.size();
                    check($sformatf("dut%0d_sb_size", g), sz, 1);
                    check($sformatf("dut%0d_rise_edges", g), nbits[g], W);
                    check($sformatf("dut%0d_cs_low_cycles", g), lowcnt[g], 2 * W * div_of(g));
                    if (sz > 0) begin
                        e = (g == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("dut%0d_frame", g), shreg[g], e);
                    end
                    nbits[g] = 0; lowcnt[g] = 0;
                    rise_cyc[g] = cyc; have_rise[g] = 1;
                end
                if (req[g] && have_rise[g]) begin
                    check($sformatf("dut%0d_gap", g), cyc - rise_cyc[g], div_of(g));
                    have_rise[g] = 0;
                end
            end
            p_sclk[g] = sclk[g];
            p_cs[g]   = cs_n[g];
            p_mosi[g] = mosi[g];
        end
    end

    // Wait for a request, answer dly cycles later, then check the frame start.
    task automatic send(input int g, input logic [7:0] s, input int dly, output int rc);
        logic [7:0] e;
        int         bad;
        bit         got;
        e = to_offset(s); bad = 0; got = 0; rc = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (req[g]) begin
                got = 1;
                rc  = cyc;
            end
        end
        check($sformatf("dut%0d_req_seen", g), got, 1);
        for (int i = 1; i <= dly; i++) begin
            @(negedge clk);
            if (cs_n[g] !== 1'b1 || sclk[g] !== 1'b0 || req[g] !== 1'b0) bad++;
            if (i == dly) begin
                data[g]  = s;
                valid[g] = 1'b1;
            end
        end
        check($sformatf("dut%0d_wait_idle", g), bad, 0);
        if (g == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        valid[g] = 1'b0;
        check($sformatf("dut%0d_start_cs", g), cs_n[g], 0);
        check($sformatf("dut%0d_start_sclk", g), sclk[g], 0);
        check($sformatf("dut%0d_start_mosi", g), mosi[g], e[7]);
    endtask

    initial begin
        int r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, a, b, c;
        rst_n = 1'b0; rst1_n = 1'b0; valid = '0; data = '0;
        #12;
        check("rst_req",   req[0],   0);
        check("rst_sclk",  sclk[0],  0);
        check("rst_mosi",  mosi[0],  0);
        check("rst_cs_n",  cs_n[0],  1);
        check("rst_unexp", unexp[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(0, 8'h7F, 1, r1);
        send(0, 8'h80, 1, r2);
        check("period_70", r2 - r1, 70);
        send(0, 8'h00, 1, r3);
        send(0, 8'hFF, 1, r4);
        check("unexp_clean", unexp[0], 0);

        send(0, 8'h40, 20, r5);
        check("period_before_delay", r5 - r4, 70);

        send(0, 8'hC5, 1, r6);
        repeat (10) @(negedge clk);
        data[0] = 8'h00; valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        check("unexp_set", unexp[0], 1);
        send(0, 8'h01, 1, r7);
        check("period_after_extra", r7 - r6, 70);
        repeat (30) @(negedge clk);
        check("unexp_sticky", unexp[0], 1);

        send(0, 8'h55, 1, r8);
        repeat (6 * 4 + 1) @(negedge clk);
        check("pre_rst_mosi_bit3", mosi[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs_n",  cs_n[0],  1);
        check("midrst_sclk",  sclk[0],  0);
        check("midrst_mosi",  mosi[0],  0);
        check("midrst_unexp", unexp[0], 0);
        check("midrst_req",   req[0],   0);
        q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h12, 1, r9);
        send(0, 8'hAA, 1, r10);
        check("period_after_rst", r10 - r9, 70);

        @(negedge clk);
        rst1_n = 1'b1;
        send(1, 8'h3C, 1, a);
        send(1, 8'hC3, 1, b);
        check("dut1_period_19", b - a, 19);
        send(1, 8'h80, 1, c);

        for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check("dut0_sb_drained", q0.size(), 0);
        check("dut1_sb_drained", q1.size(), 0);
        check("dut0_pin_rules", viol[0], 0);
        check("dut1_pin_rules", viol[1], 0);
        check("dut1_unexp", unexp[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
